// File: rtl/l2_responder.sv
// l2_responder: fixed-latency L2 word-array responder; define L2_RESPONDER_BOUNDS_CHECK_EN to route bad requests to ERROR
module l2_responder #(
   parameter int          LATENCY     = 4,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        l2REN,
   input  logic        l2WEN,
   input  logic [31:0] l2addr,
   input  logic [31:0] l2store,
   input  logic [3:0]  l2_byte_en,
   output logic [31:0] l2load,
   output logic [1:0]  l2state,
   output logic        l2error
);
   typedef enum logic [1:0] {L2_FREE = 2'd0, L2_BUSY = 2'd1, L2_ACCESS = 2'd2, L2_ERROR = 2'd3} l2_state_t;
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   l2_state_t   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d, be_q, be_d, acc_be;
   logic        wr_q, wr_d, acc_wr, req, err, go_acc, unused_ok;
   logic [31:0] addr_q, addr_d, data_q, data_d, load_q, load_d;
   logic [31:0] acc_addr, acc_data, off;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH_WORDS];
   assign req = l2REN | l2WEN;
   // zero latency enters ACCESS straight from FREE, so the access uses the live inputs
   assign acc_addr = state_q == L2_FREE ? l2addr : addr_q;
   assign acc_data = state_q == L2_FREE ? l2store : data_q;
   assign acc_be   = state_q == L2_FREE ? l2_byte_en : be_q;
   assign acc_wr   = state_q == L2_FREE ? l2WEN : wr_q;
   assign off = acc_addr - BASE_ADDR;
   assign idx = AW'(off[31:2] % 30'(DEPTH_WORDS));
   assign unused_ok = ^off[1:0];
`ifdef L2_RESPONDER_BOUNDS_CHECK_EN
   logic [31:0] in_off;
   assign in_off  = l2addr - BASE_ADDR;
   assign err     = l2addr < BASE_ADDR || {1'b0, in_off} >= 33'(DEPTH_WORDS) * 33'd4 ||
                    l2addr[1:0] != 2'b00 || (l2REN && l2WEN);
   assign l2error = state_q == L2_ERROR;
`else
   assign err     = 1'b0;
   assign l2error = 1'b0;
`endif
   // next state, latency counter, request capture and read-data selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      case (state_q)
         L2_FREE: if (req) begin
            wr_d    = l2WEN;
            addr_d  = l2addr;
            data_d  = l2store;
            be_d    = l2_byte_en;
            cnt_d   = 4'(LATENCY);
            state_d = err ? L2_ERROR : (LATENCY == 0 ? L2_ACCESS : L2_BUSY);
         end
         L2_BUSY: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? L2_ACCESS : L2_BUSY;
         end
         default: state_d = L2_FREE;
      endcase
      go_acc = state_d == L2_ACCESS && state_q != L2_ACCESS;
      load_d = go_acc && !acc_wr ? mem[idx] : (state_d == L2_ERROR ? 32'h0 : load_q);
   end
   // state and captured request; reset discards any transaction in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= L2_FREE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 32'h0;
         data_q  <= 32'h0;
         be_q    <= 4'h0;
         load_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         load_q  <= load_d;
      end
   end
   // word array: byte-lane write on entry to ACCESS, contents survive reset
   always_ff @(posedge CLK) begin
      for (int n = 0; n < 4; n++)
         if (!RST && go_acc && acc_wr && acc_be[n]) mem[idx][8*n +: 8] <= acc_data[8*n +: 8];
   end
   assign l2state = state_q;
   assign l2load  = load_q;
endmodule

// File: tb/tb_l2_responder.sv
// tb_l2_responder: randomized scoreboard bench for l2_responder (LATENCY=4) plus a LATENCY=0 directed check
module tb_l2_responder;
   localparam int LAT = 4;
   localparam int DEPTH = 1024;
   typedef struct {int due; logic err; logic [31:0] load;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic ren = 1'b0, wen = 1'b0, ren0 = 1'b0, wen0 = 1'b0;
   logic [31:0] addr = 32'h0, st = 32'h0, addr0 = 32'h0, st0 = 32'h0;
   logic [3:0] be = 4'h0, be0 = 4'h0;
   logic [31:0] load, load0;
   logic [1:0] state, state0;
   logic error, error0;
   int cyc = 0, checks = 0, errors = 0;
   logic mon_en = 1'b0, prev_done = 1'b0;
   exp_t q[$];
   logic [31:0] mdl [DEPTH];
   logic [31:0] last_load = 32'h0;

   l2_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) u1 (
      .CLK(clk), .RST(rst), .l2REN(ren), .l2WEN(wen), .l2addr(addr), .l2store(st),
      .l2_byte_en(be), .l2load(load), .l2state(state), .l2error(error));
   l2_responder #(.LATENCY(0), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) u0 (
      .CLK(clk), .RST(rst), .l2REN(ren0), .l2WEN(wen0), .l2addr(addr0), .l2store(st0),
      .l2_byte_en(be0), .l2load(load0), .l2state(state0), .l2error(error0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // one transaction: predict outcome from the address/op rules, push it, then hold the bus for its duration
   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      logic e_err;
      int idx, span;
      logic [31:0] mask;
`ifdef L2_RESPONDER_BOUNDS_CHECK_EN
      e_err = a >= 32'(4 * DEPTH) || a[1:0] != 2'b00 || (r && w);
`else
      e_err = 1'b0;
`endif
      idx  = int'((a >> 2) % DEPTH);
      mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      if (e_err) last_load = 32'h0;
      else if (w) mdl[idx] = (mdl[idx] & ~mask) | (d & mask);
      else last_load = mdl[idx];
      span = e_err ? 1 : LAT + 1;
      @(negedge clk);
      e.due = cyc + span;
      e.err = e_err;
      e.load = last_load;
      q.push_back(e);
      ren = r; wen = w; addr = a; st = d; be = b;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         if (k < span) begin
            ren = 1'($urandom_range(0, 1)); wen = 1'($urandom_range(0, 1));
            addr = $urandom; st = $urandom; be = 4'($urandom);
         end else begin
            ren = 1'b0; wen = 1'b0;
         end
      end
   endtask

   // monitor: every ACCESS/ERROR cycle pops and checks the oldest expected response
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (prev_done) check("free_after_done", 32'(state), 32'd0);
         if (state == 2'd2 || state == 2'd3) begin
            if (q.size() == 0) check("unexpected_response", 32'(state), 32'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               check("resp_cycle", 32'(cyc), 32'(e.due));
               check("resp_state", 32'(state), e.err ? 32'd3 : 32'd2);
               check("resp_error", 32'(error), 32'(e.err));
               check("resp_load", load, e.load);
            end
         end else check("error_idle", 32'(error), 32'd0);
         prev_done = state == 2'd2 || state == 2'd3;
      end
   end

   initial begin
      int kind, k;
      logic r, w;
      logic [31:0] a;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_load", load, 32'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(4 * i), $urandom, 4'hF);
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
      issue(1'b0, 1'b1, 32'h14, 32'h12345678, 4'b0000);
      issue(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
      issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
      issue(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      // write 0x55 to 0x20, reset during BUSY cycle 2: nothing commits and l2load clears
      @(negedge clk);
      ren = 1'b0; wen = 1'b1; addr = 32'h20; st = 32'h55; be = 4'hF;
      @(negedge clk);
      wen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_load", load, 32'h0);
      check("midrst_error", 32'(error), 32'd0);
      rst = 1'b0;
      prev_done = 1'b0;
      last_load = 32'h0;
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      for (int n = 0; n < 250; n++) begin
         kind = $urandom_range(0, 9);
         k = $urandom_range(0, 15);
         w = 1'($urandom_range(0, 1));
         r = ~w;
         a = 32'(4 * k);
         if (kind == 0) a = 32'h1000 + 32'(4 * k);
         else if (kind == 1) a = a + 32'($urandom_range(1, 3));
         else if (kind == 2) begin r = 1'b1; w = 1'b1; end
         issue(r, w, a, $urandom, 4'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      mon_en = 1'b0;
      // LATENCY=0 instance: ACCESS directly in cycle 1, FREE in cycle 2
      @(negedge clk);
      wen0 = 1'b1; addr0 = 32'h10; st0 = 32'hCAFEF00D; be0 = 4'hF;
      @(negedge clk);
      wen0 = 1'b0;
      check("l0_wr_access", 32'(state0), 32'd2);
      @(negedge clk);
      check("l0_wr_free", 32'(state0), 32'd0);
      ren0 = 1'b1;
      @(negedge clk);
      ren0 = 1'b0;
      check("l0_rd_access", 32'(state0), 32'd2);
      check("l0_rd_load", load0, 32'hCAFEF00D);
      @(negedge clk);
      check("l0_rd_free", 32'(state0), 32'd0);
      check("l0_rd_hold", load0, 32'hCAFEF00D);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, the number of L2_BUSY cycles per transaction (legal range 0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, the size of the internal 32-bit word array.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 l2REN  input  1  read request from the bus controller.
REQ-007 l2WEN  input  1  write request from the bus controller.
REQ-008 l2addr  input  32  byte address of the request.
REQ-009 l2store  input  32  write data.
REQ-010 l2_byte_en  input  4  write byte lanes; bit n selects bits [8n+7:8n].
REQ-011 l2load  output  32  read data, registered.
REQ-012 l2state  output  2  l2_state_t encoding: L2_FREE=0, L2_BUSY=1, L2_ACCESS=2, L2_ERROR=3.
REQ-013 l2error  output  1  high only while l2state==L2_ERROR.

Function
REQ-014 SHALL implement an FSM with states FREE, BUSY, ACCESS, ERROR; l2state SHALL equal the current state.
REQ-015 In FREE, (l2REN|l2WEN)==1 at a rising edge SHALL capture op, l2addr, l2store and l2_byte_en (cycle 0).
REQ-016 After capture: BUSY for cycles 1..LATENCY, ACCESS for exactly cycle LATENCY+1, FREE in cycle LATENCY+2.
REQ-017 If LATENCY==0, the block SHALL go FREE->ACCESS directly, with ACCESS in cycle 1.
REQ-018 A down-counter, loaded with LATENCY at capture, SHALL decrement once per BUSY cycle; the transition to ACCESS occurs when it reaches 1 (or immediately when LATENCY==0).
REQ-019 Reads: the word array SHALL be read on the edge entering ACCESS, so l2load is valid throughout ACCESS.
REQ-020 l2load SHALL hold its value until the next read ACCESS or ERROR.
REQ-021 Reads SHALL return the full word regardless of l2_byte_en.
REQ-022 Writes: on the edge entering ACCESS, only the lanes with captured byte_en=1 SHALL be updated; byte_en=4'b0000 still completes via ACCESS with no change to the array.
REQ-023 Array index = (captured addr - BASE_ADDR) >> 2.
REQ-024 Inputs SHALL be ignored outside FREE; deasserting the request or changing the address during BUSY SHALL NOT abort or alter the transaction.
REQ-025 The requester SHALL drop l2REN/l2WEN in the ACCESS/ERROR cycle; a request still high in the following FREE cycle SHALL start a new transaction.
REQ-026 ERROR SHALL last exactly one cycle, then FREE; l2load=0 during ERROR; no array write.
REQ-027 A request that errors SHALL enter ERROR in cycle 1 without any BUSY cycles.

Reset
REQ-028 RST=1 at an edge SHALL force state=FREE, counter=0, l2load=32'h0 and discard the captured request, from any state including mid-BUSY.
REQ-029 Array contents SHALL NOT be modified by reset; a write in progress during reset SHALL NOT commit.
REQ-030 Outputs after reset: l2state=L2_FREE, l2error=0, l2load=0.

Configuration
REQ-031 Macro L2_RESPONDER_BOUNDS_CHECK_EN defined: the following SHALL go to ERROR:
- addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
- addr[1:0]!=0
- l2REN and l2WEN both high at capture.
REQ-032 Macro undefined: ERROR is unreachable and l2error is tied 0; the index wraps modulo DEPTH_WORDS; addr[1:0] is ignored; REN&WEN is treated as a write.

Verification (LATENCY=4, DEPTH_WORDS=1024, BASE_ADDR=0, macro defined unless noted)
REQ-033 Write 0xDEADBEEF to 0x10, byte_en=4'hF -> BUSY cycles 1-4, ACCESS cycle 5, FREE cycle 6; then read 0x10 -> l2load=0xDEADBEEF in its ACCESS cycle.
REQ-034 Write 0x11223344 to 0x10 with byte_en=4'b0101, then read 0x10 -> l2load=0xDE22BE44.
REQ-035 Read 0x1000 -> l2state=L2_ERROR with l2error=1 and l2load=0 in cycle 1, FREE in cycle 2; with the macro undefined, the same read returns word 0 after the normal latency and l2error stays 0.
REQ-036 Write 0x55 to 0x20 (prior value 0), RST=1 in cycle 2 -> FREE and l2load=0 the next cycle; a subsequent read of 0x20 returns 0x0.
REQ-037 Read 0x10 with l2REN dropped in cycle 2 -> ACCESS still occurs in cycle 5 with the correct data.
REQ-038 LATENCY=0, read 0x10 -> ACCESS in cycle 1 with the data, FREE in cycle 2, no BUSY cycles.
